// File: rtl/instr_fetch_pkg.sv
// Shared RISC-V definitions for the instruction fetch slice: opcodes,
// the canonical NOP, fetch FSM states and the B-type immediate decoder.
package riscv_pkg;

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [6:0]  OP_B   = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // Sign-extended B-type immediate; opcode is not checked.
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    logic unused_bits;
    unused_bits = ^{instr[24:12], instr[6:0]};
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: instruction-memory req/ack channel plus the
// instruction/decoder handshake. master = fetch unit, slave = mem/decoder.
interface instr_fetch_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [6:0]      cmdOp;
  logic [2:0]      cmdF3;
  logic [6:0]      cmdF7;
  logic [XLEN-1:0] pc;
  logic            pcSrc;
  logic            err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, cmdOp, cmdF3, cmdF7, pc, err,
    input  imem_ack, imem_rdata, instr_ready, pcSrc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, cmdOp, cmdF3, cmdF7, pc, err,
    output imem_ack, imem_rdata, instr_ready, pcSrc
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word per req/ack
// transaction, presents it to the decoder and picks the next PC from pcSrc.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] next_pc;

  // State register; async reset puts every output at its reset value at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state, fetch handshake and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = err_q;
    next_pc = pc_q + (bus.pcSrc ? imm_b(instr_q) : 32'd4);

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        // First REQ cycle only raises req; ack counts once req is visible.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && bus.instr_ready) begin
          valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.cmdOp       = instr_q[6:0];
  assign bus.cmdF3       = instr_q[14:12];
  assign bus.cmdF7       = instr_q[31:25];
  assign bus.pc          = pc_q;
  assign bus.err         = err_q;

endmodule
